// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-write port between the pipeline and the UART transmitter.
//
// Write handshake: `we` acts as valid and `!full` as ready. A byte is accepted on a
// rising clock edge where `we` is high and `full` (a decode of registered state) is
// low. A byte offered while `full` is high is dropped and latches `overflow`; the
// pipeline is expected to interlock on `full` so that this never happens.
//
// Signals:
//   wdata[7:0]  master->slave  byte to transmit
//   we          master->slave  write strobe, one byte per asserted cycle
//   full        slave->master  FIFO holds FIFO_DEPTH bytes
//   busy        slave->master  bytes buffered or a frame in flight
//   overflow    slave->master  sticky: a write was dropped
//   txd         slave->master  serial line, idle high
//   dbg_*       slave->master  FSM state, FIFO count, pointers and bit index
//
// FIFO_DEPTH must match the parameter of the attached uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    wdata;
    logic          we;
    logic          full;
    logic          busy;
    logic          overflow;
    logic          txd;
    logic [1:0]    dbg_state;
    logic [AW:0]   dbg_cnt;
    logic [AW-1:0] dbg_rp;
    logic [AW-1:0] dbg_wp;
    logic [2:0]    dbg_bi;

    modport master (
        output wdata, we,
        input  full, busy, overflow, txd,
        input  dbg_state, dbg_cnt, dbg_rp, dbg_wp, dbg_bi
    );

    modport slave (
        input  wdata, we,
        output full, busy, overflow, txd,
        output dbg_state, dbg_cnt, dbg_rp, dbg_wp, dbg_bi
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a circular byte FIFO.
//
// Bytes written through the interface are buffered and sent LSB first as
// start(0), 8 data bits, stop(1); each bit lasts CLK_PER_BIT clocks. When a
// stop bit ends with more bytes queued, the next start bit follows with no
// idle gap.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset; abandons any frame, empties the FIFO
//   bus   uart_tx_fifo_if.slave (wdata/we in; full/busy/overflow/txd/dbg_* out)
//
// Parameters:
//   CLK_PER_BIT  clocks per serial bit, >= 2
//   FIFO_DEPTH   byte entries, power of two, >= 2
module uart_tx_fifo #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic           clk,
    input  logic           rstn,
    uart_tx_fifo_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLK_PER_BIT);
    localparam logic [BW-1:0] BC_LAST  = BW'(CLK_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [BW-1:0] bc_q, bc_d;
    logic [2:0]    bi_q, bi_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;

    // Storage is not reset: an entry is only read after it has been written.
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          full_w;
    logic          bit_end;
    logic          push;
    logic          pop;

    always_comb begin
        full_w  = (cnt_q == CNT_FULL);
        bit_end = (bc_q == BC_LAST);
        // Acceptance looks only at the count registered at the start of the
        // cycle, so a pop in the same cycle never frees room for this write.
        push    = bus.we && !full_w;
        ovf_d   = ovf_q | (bus.we & full_w);

        pop     = 1'b0;
        state_d = state_q;
        bc_d    = bc_q;
        bi_d    = bi_q;
        sh_d    = sh_q;

        case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rp_q];
                    bc_d    = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bc_d    = '0;
                    bi_d    = '0;
                    state_d = DATA;
                end else begin
                    bc_d = bc_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bc_d = '0;
                    sh_d = {1'b0, sh_q[7:1]};
                    if (bi_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bi_d = bi_q + 3'd1;
                    end
                end else begin
                    bc_d = bc_q + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    bc_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (cnt_q != '0) begin
                        pop     = 1'b1;
                        sh_d    = mem_q[rp_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bc_d = bc_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        rp_d = pop  ? rp_q + AW'(1) : rp_q;
        wp_d = push ? wp_q + AW'(1) : wp_q;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase

        // txd is registered from the next state so the line changes on the
        // same edge as the FSM and carries no decode glitches.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = sh_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rp_q    <= '0;
            wp_q    <= '0;
            cnt_q   <= '0;
            bc_q    <= '0;
            bi_q    <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            cnt_q   <= cnt_d;
            bc_q    <= bc_d;
            bi_q    <= bi_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= bus.wdata;
        end
    end

    assign bus.txd       = txd_q;
    assign bus.full      = full_w;
    assign bus.busy      = (cnt_q != '0) || (state_q != IDLE);
    assign bus.overflow  = ovf_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_cnt   = cnt_q;
    assign bus.dbg_rp    = rp_q;
    assign bus.dbg_wp    = wp_q;
    assign bus.dbg_bi    = bi_q;
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-oriented UART transmitter with an input FIFO: the consuming end of the 8-bit UART write data that the main-core decode stage drives on an Outll instruction. It buffers bytes written by the pipeline and serialises them as 8N1 frames on the `txd` line. It returns a `full` flag, which the pipeline folds into its interlock so that no write is issued while the buffer cannot accept it.

## Interface
- `CLK_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal values are ≥ 2.
- `FIFO_DEPTH`, default 16: number of byte entries. Must be a power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `wdata`  in  8  byte to transmit.
- `we`  in  1  write strobe; one byte per asserted cycle.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes; the pipeline interlocks on it.
- `busy`  out  1  FIFO not empty or a frame is in flight.
- `overflow`  out  1  sticky; set when a write is dropped.
- `txd`  out  1  serial line, idle high.

## Operation
- The FIFO is a circular buffer with read pointer `rp`, write pointer `wp`, and count `cnt`.
  - `rp` and `wp` are log2(FIFO_DEPTH) bits wide and wrap modulo depth.
  - `cnt` is log2(FIFO_DEPTH)+1 bits wide.
- Push rule:
  - If `we` is high and `full` is low, the byte is written at `wp`, and `wp` and `cnt` increment.
  - If `we` is high and `full` is high, the byte is dropped, `overflow` sets to 1, and no other state changes.
- Pop: the FSM reads the entry at `rp` into its shift register; `rp` increments and `cnt` decrements.
- Simultaneous push and pop: `cnt` is unchanged and both pointers advance. Acceptance of the push is decided only by the `full` value registered at the start of that cycle.
- `full` = (`cnt` == FIFO_DEPTH). `busy` = (`cnt` != 0) or (state != IDLE). Both are decoded from registers.
- FSM states are IDLE, START, DATA, and STOP. A baud counter `bc` counts 0..CLK_PER_BIT-1, and a bit index `bi` counts 0..7.
- IDLE:
  - `txd` = 1.
  - If `cnt` != 0: pop, load the byte into `sh`, clear `bc`, and go to START.
- START:
  - `txd` = 0 for CLK_PER_BIT cycles, then go to DATA with `bi` = 0.
- DATA:
  - `txd` = `sh[0]`, so bits go out LSB first.
  - At `bc` = CLK_PER_BIT-1, shift `sh` right. If `bi` = 7 go to STOP; otherwise increment `bi`.
- STOP:
  - `txd` = 1 for CLK_PER_BIT cycles.
  - At the end: if `cnt` != 0, pop and go directly to START with no idle gap; otherwise go to IDLE.
- `txd` is driven from a register, so it carries no combinational glitches.
- Reset (asynchronous, at any time including mid-frame):
  - Everything clears: `rp` = `wp` = `cnt` = 0, state = IDLE, `bc` = `bi` = 0, `sh` = 0.
  - Outputs: `txd` = 1, `full` = 0, `busy` = 0, `overflow` = 0.
  - Any partially sent frame is abandoned and buffered bytes are discarded.

## Timing
- Write latency: `we` at edge N makes `cnt` and `busy` update after edge N.
- Start-bit latency: with an empty FIFO in IDLE, the FSM pops at edge N+1 and `txd` falls after edge N+1. The falling edge therefore appears one cycle after `cnt` goes non-zero.
- A frame is exactly 10·CLK_PER_BIT cycles. Each bit, start and stop included, holds for exactly CLK_PER_BIT cycles.
- Back-to-back bytes have a period of exactly 10·CLK_PER_BIT cycles.
- `full` deasserts in the cycle after the pop that relieves it.
- `full` is registered. A write issued in the same cycle that `full` rises is still accepted only if `cnt` was below depth at the start of that cycle, per the push rule.
- Sustained throughput is one byte per 10·CLK_PER_BIT cycles. Up to FIFO_DEPTH writes are absorbed with no interlock.

## Test plan
- Single byte, CLK_PER_BIT = 4:
  - Stimulus: write 0x55 in IDLE.
  - Required `txd`: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 each for 4 cycles, then 1 for 4 cycles. 40 cycles total.
  - Required `busy`: falls after the stop bit.
- Back-to-back, CLK_PER_BIT = 4:
  - Stimulus: write 0x00 and 0xFF on consecutive cycles.
  - Required: the second start bit begins exactly 40 cycles after the first, with no idle cycle between frames.
- Fill, FIFO_DEPTH = 4:
  - Stimulus: 5 consecutive writes 0x01..0x05 while the first frame is in flight.
  - Required: the first byte is popped, so `full` rises after the 5th write and `overflow` stays 0.
  - Required: all five bytes appear on `txd` in order.
- Overflow:
  - Stimulus: with `full` = 1, write 0xAA.
  - Required: `overflow` = 1, `cnt` is unchanged, and 0xAA is never transmitted.
- Simultaneous push and pop:
  - Stimulus: with `cnt` = 3, write a byte on the same cycle STOP ends and pops.
  - Required: `cnt` stays 3 and both pointers advance, including `wp` wrapping from 3 to 0.
- Reset mid-frame:
  - Stimulus: drop `rstn` during DATA bit 4 with 2 bytes queued.
  - Required: `txd` = 1 immediately (asynchronous), with `busy`, `full`, and `overflow` all 0.
  - Required: after release, no further frames appear.
